// File: rtl/poc_print_arbiter_pkg.sv
// Shared types and constants for the poc print arbiter.
// Optional build macro: POC_ARB_IRQ_EN (interrupt-driven completion instead of SR7 polling).
package poc_arb_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SETUP,
    WRITE,
    POLL,
    DONE
  } state_t;

  localparam logic [2:0] SR_MODE_ADDR  = 3'd0;
  localparam logic [2:0] SR_READY_ADDR = 3'd7;

  // SR7 reads 1 when the poc can take a new byte; writing 0 starts the print.
  localparam logic POC_READY = 1'b1;
  localparam logic POC_BUSY  = 1'b0;

endpackage

// File: rtl/poc_print_arbiter_if.sv
// Requester-side and poc-side signal bundle of the print arbiter.
interface poc_print_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   grant;
  logic               done;
  logic               busy;
  logic [7:0]         poc_data;
  logic               poc_rw;
  logic               poc_reg_in;
  logic [2:0]         poc_addr;
  logic               poc_reg_out;
  logic               poc_irq;

  modport master (
    input  req, req_data, poc_reg_out, poc_irq,
    output grant, done, busy, poc_data, poc_rw, poc_reg_in, poc_addr
  );

  modport slave (
    output req, req_data, poc_reg_out, poc_irq,
    input  grant, done, busy, poc_data, poc_rw, poc_reg_in, poc_addr
  );

endinterface

// File: rtl/poc_print_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request after ptr, with wrap.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/poc_print_arbiter.sv
// Round-robin arbiter sharing one poc printer controller among N_REQ requesters.
// Optional build macro: POC_ARB_IRQ_EN (INIT write of SR0, completion on poc_irq low).
module poc_print_arbiter
  import poc_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int SETUP_CYCLES = 3,
  parameter int POLL_SKIP    = 2
) (
  input logic                 clk,
  input logic                 rst,
  poc_print_arbiter_if.master bus
);

  localparam int IW      = $clog2(N_REQ);
  localparam int CNT_MAX = (SETUP_CYCLES > POLL_SKIP) ? SETUP_CYCLES : POLL_SKIP;
  localparam int CW      = $clog2(CNT_MAX + 1);

`ifdef POC_ARB_IRQ_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [IW-1:0]    ptr_q, ptr_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic [7:0]       data_q, data_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;
  logic             rw_q, rw_n;
  logic             reg_in_q, reg_in_n;
  logic [2:0]       addr_q, addr_n;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             grant_ok;
  logic             poll_ok;
  logic [7:0]       req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = bus.req_data[8*g +: 8];
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef POC_ARB_IRQ_EN
  logic reg_out_unused;
  assign reg_out_unused = bus.poc_reg_out;
  assign grant_ok       = (bus.poc_irq == 1'b0);
  assign poll_ok        = (bus.poc_irq == 1'b0);
`else
  logic irq_unused;
  assign irq_unused = bus.poc_irq;
  assign grant_ok   = (bus.poc_reg_out == POC_READY);
  assign poll_ok    = (bus.poc_reg_out == POC_READY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      ptr_q    <= IW'(N_REQ - 1);
      idx_q    <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
`ifdef POC_ARB_IRQ_EN
      busy_q   <= 1'b1;
      rw_q     <= 1'b1;
      reg_in_q <= 1'b1;
      addr_q   <= SR_MODE_ADDR;
`else
      busy_q   <= 1'b0;
      rw_q     <= 1'b0;
      reg_in_q <= 1'b0;
      addr_q   <= SR_READY_ADDR;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      ptr_q    <= ptr_n;
      idx_q    <= idx_n;
      grant_q  <= grant_n;
      data_q   <= data_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
      rw_q     <= rw_n;
      reg_in_q <= reg_in_n;
      addr_q   <= addr_n;
    end
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ptr_n   = ptr_q;
    idx_n   = idx_q;
    grant_n = grant_q;
    data_n  = data_q;
    unique case (state_q)
      INIT: state_n = IDLE;
      IDLE: begin
        if (pick_valid && grant_ok) begin
          state_n = SETUP;
          grant_n = pick_onehot;
          idx_n   = pick_idx;
          data_n  = req_bytes[pick_idx];
          cnt_n   = CW'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_n = WRITE;
        else             cnt_n   = cnt_q - CW'(1);
      end
      WRITE: begin
        state_n = POLL;
        cnt_n   = CW'(POLL_SKIP);
      end
      POLL: begin
        if (cnt_q != '0) cnt_n   = cnt_q - CW'(1);
        else if (poll_ok) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        ptr_n   = idx_q;
      end
      default: state_n = IDLE;
    endcase

    rw_n     = (state_n == WRITE) || (state_n == INIT);
    addr_n   = (state_n == INIT) ? SR_MODE_ADDR : SR_READY_ADDR;
    reg_in_n = (state_n == INIT) ? 1'b1 : POC_BUSY;
    done_n   = (state_n == DONE);
    busy_n   = (state_n != IDLE);
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.poc_data   = data_q;
  assign bus.poc_rw     = rw_q;
  assign bus.poc_reg_in = reg_in_q;
  assign bus.poc_addr   = addr_q;

endmodule
